// File: rtl/lcd_pkg.sv
// Shared HD44780 command constants, FSM encodings and bus helpers
// for the watch LCD bus arbiter.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET_8B2L = 8'h3C;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] ENTRY_INC     = 8'h06;
  localparam logic [7:0] CLEAR         = 8'h01;

  typedef enum logic [3:0] {
    S_PWRUP = 4'd0,
    S_FSET  = 4'd1,
    S_DISP  = 4'd2,
    S_ENTRY = 4'd3,
    S_CLR   = 4'd4,
    S_IDLE  = 4'd5,
    S_XFER  = 4'd6,
    S_ACK   = 4'd7
  } state_t;

  typedef struct packed {
    logic       e;
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } lcd_bus_t;

  localparam lcd_bus_t IDLE_BUS = '{
    e: 1'b0, rs: 1'b1, rw: 1'b1, data: 8'h00
  };

  function automatic lcd_bus_t bus_drive(
    input logic       e,
    input logic       rs,
    input logic [7:0] data
  );
    return '{e: e, rs: rs, rw: 1'b0, data: data};
  endfunction

  function automatic logic [7:0] init_cmd(input state_t s);
    logic [7:0] c;
    c = 8'h00;
    case (s)
      S_FSET:  c = FUNC_SET_8B2L;
      S_DISP:  c = DISP_ON;
      S_ENTRY: c = ENTRY_INC;
      S_CLR:   c = CLEAR;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic state_t init_next(input state_t s);
    state_t n;
    n = S_IDLE;
    case (s)
      S_FSET:  n = S_DISP;
      S_DISP:  n = S_ENTRY;
      S_ENTRY: n = S_CLR;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after
// the pointer, wrapping at N_REQ.
module lcd_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] win,
  output logic [PW-1:0]    idx,
  output logic             valid
);

  int j;

  always_comb begin
    win   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr) + i) % N_REQ;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        win[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Character-LCD bus owner: HD44780 init sequence after reset, then
// round-robin shared write port with request/grant/ack and bursts.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int PWRUP_CYC = 70,
  parameter int XFER_CYC  = 4,
  parameter int CMD_GAP   = 2
) (
  input  logic               CLK_1k,
  input  logic               RESET,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_rs,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   ack,
  output logic               init_done,
  output logic               LCD_E,
  output logic               LCD_RS,
  output logic               LCD_RW,
  output logic [7:0]         LCD_DATA
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = 16;

  localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_CYC);
  localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_CYC - 1);
  localparam logic [CW-1:0] E_LAST     = CW'(XFER_CYC - 2);
  localparam logic [CW-1:0] XFER_LEN   = CW'(XFER_CYC);
  localparam logic [CW-1:0] GAP_LAST   = CW'(XFER_CYC + CMD_GAP - 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(XFER_CYC + CMD_GAP + 1);
  localparam logic [PW-1:0] OWN_LAST   = PW'(N_REQ - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [CW-1:0]   init_last;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   pick_idx;
  logic [N_REQ-1:0] pick;
  logic            pick_valid;
  lcd_bus_t        bus;

  lcd_rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr (
    .req   (req),
    .ptr   (ptr),
    .win   (pick),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign cnt_nxt   = cnt + CW'(1);
  assign init_last = (state == S_CLR) ? CLR_LAST : GAP_LAST;

  // E is high only in the middle of a transfer so data settles
  // before the rising edge and holds after the falling edge.
  function automatic logic e_at(input logic [CW-1:0] c);
    return (c != '0) && (c <= E_LAST);
  endfunction

  always_ff @(posedge CLK_1k) begin
    if (!RESET) begin
      state     <= S_PWRUP;
      cnt       <= '0;
      ptr       <= '0;
      owner     <= '0;
      grant     <= '0;
      ack       <= '0;
      init_done <= 1'b0;
      bus       <= IDLE_BUS;
    end else begin
      ack <= '0;
      case (state)
        S_PWRUP: begin
          if (cnt == PWRUP_LAST) begin
            state <= S_FSET;
            cnt   <= '0;
            bus   <= bus_drive(1'b0, 1'b0, FUNC_SET_8B2L);
          end else begin
            cnt <= cnt_nxt;
          end
        end
        S_FSET, S_DISP, S_ENTRY, S_CLR: begin
          if (cnt == init_last) begin
            cnt <= '0;
            if (state == S_CLR) begin
              state     <= S_IDLE;
              init_done <= 1'b1;
              bus       <= IDLE_BUS;
            end else begin
              state <= init_next(state);
              bus   <= bus_drive(1'b0, 1'b0,
                                 init_cmd(init_next(state)));
            end
          end else begin
            cnt <= cnt_nxt;
            if (cnt_nxt < XFER_LEN)
              bus <= bus_drive(e_at(cnt_nxt), 1'b0,
                               init_cmd(state));
            else
              bus <= IDLE_BUS;
          end
        end
        S_IDLE: begin
          if (pick_valid) begin
            grant <= pick;
            owner <= pick_idx;
            state <= S_XFER;
            cnt   <= '0;
            bus   <= bus_drive(1'b0, req_rs[pick_idx],
                               req_data[8*pick_idx +: 8]);
          end
        end
        S_XFER: begin
          if (cnt == XFER_LAST) begin
            state <= S_ACK;
            cnt   <= '0;
            ack   <= grant;
            bus   <= IDLE_BUS;
          end else begin
            cnt   <= cnt_nxt;
            bus.e <= e_at(cnt_nxt);
          end
        end
        S_ACK: begin
          // A still-asserted request on the ack cycle extends the burst.
          if (req[owner]) begin
            state <= S_XFER;
            cnt   <= '0;
            bus   <= bus_drive(1'b0, req_rs[owner],
                               req_data[8*owner +: 8]);
          end else begin
            state <= S_IDLE;
            grant <= '0;
            ptr   <= (owner == OWN_LAST) ? '0 : owner + PW'(1);
          end
        end
        default: begin
          state <= S_PWRUP;
          cnt   <= '0;
          grant <= '0;
          bus   <= IDLE_BUS;
        end
      endcase
    end
  end

  assign LCD_E    = bus.e;
  assign LCD_RS   = bus.rs;
  assign LCD_RW   = bus.rw;
  assign LCD_DATA = bus.data;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter: table of single writes,
// scoreboard of expected LCD bytes, hand sequences for corner cases.
module tb_lcd_bus_arbiter;

  logic        clk = 1'b0;
  logic        RESET = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  req_rs = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        init_done;
  logic        LCD_E;
  logic        LCD_RS;
  logic        LCD_RW;
  logic [7:0]  LCD_DATA;

  always #5 clk = ~clk;

  lcd_bus_arbiter #(
    .N_REQ     (4),
    .PWRUP_CYC (70),
    .XFER_CYC  (4),
    .CMD_GAP   (2)
  ) dut (
    .CLK_1k    (clk),
    .RESET     (RESET),
    .req       (req),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .grant     (grant),
    .ack       (ack),
    .init_done (init_done),
    .LCD_E     (LCD_E),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .LCD_DATA  (LCD_DATA)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [3:0] grant;
  } xfer_t;

  typedef struct {
    int         idx;
    logic       rs;
    logic [7:0] data;
    logic [3:0] exp_grant;
  } wr_t;

  xfer_t exp_q[$];
  xfer_t mon_x;
  int    n_chk = 0;
  int    n_fail = 0;
  int    ack_cnt[4] = '{0, 0, 0, 0};
  int    e_w = 0;
  logic  e_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic rs, input logic [7:0] d,
                      input logic [3:0] g);
    xfer_t x;
    x.rs = rs;
    x.data = d;
    x.grant = g;
    exp_q.push_back(x);
  endtask

  task automatic push_init();
    push(1'b0, 8'h3C, 4'b0000);
    push(1'b0, 8'h0C, 4'b0000);
    push(1'b0, 8'h06, 4'b0000);
    push(1'b0, 8'h01, 4'b0000);
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 20 && grant == 4'b0000; i++) tick();
  endtask

  task automatic wait_ack(input int idx);
    for (int i = 0; i < 40 && ack[idx] !== 1'b1; i++) tick();
    chk($sformatf("ack%0d_seen", idx), 32'(ack[idx]), 32'd1);
  endtask

  task automatic do_write(input wr_t w);
    req[w.idx] = 1'b1;
    req_rs[w.idx] = w.rs;
    req_data[8*w.idx +: 8] = w.data;
    push(w.rs, w.data, w.exp_grant);
    wait_grant();
    chk("wr_grant", 32'(grant), 32'(w.exp_grant));
    wait_ack(w.idx);
    chk("wr_ack", 32'(ack), 32'(w.exp_grant));
    req[w.idx] = 1'b0;
    tick();
    chk("wr_ack_pulse", 32'(ack), 32'd0);
    chk("wr_release", 32'(grant), 32'd0);
  endtask

  // Bus monitor: invariants every cycle, scoreboard on each E rise.
  always begin
    @(posedge clk);
    #1;
    chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    chk("ack_in_grant", 32'(ack & ~grant), 32'd0);
    for (int i = 0; i < 4; i++)
      if (ack[i]) ack_cnt[i]++;
    if (LCD_E && !e_prev) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL xfer_unexpected: data 0x%0h rs %0b grant %b",
                 LCD_DATA, LCD_RS, grant);
      end else begin
        mon_x = exp_q.pop_front();
        chk("xfer_data", 32'(LCD_DATA), 32'(mon_x.data));
        chk("xfer_rs", 32'(LCD_RS), 32'(mon_x.rs));
        chk("xfer_rw", 32'(LCD_RW), 32'd0);
        chk("xfer_grant", 32'(grant), 32'(mon_x.grant));
      end
    end
    if (!LCD_E && e_prev && RESET)
      chk("e_width", 32'(e_w), 32'd2);
    e_w = LCD_E ? e_w + 1 : 0;
    e_prev = LCD_E;
  end

  initial begin
    wr_t tbl[4];
    int  cyc;
    int  snap;

    tbl[0] = '{idx: 1, rs: 1'b1, data: 8'h41, exp_grant: 4'b0010};
    tbl[1] = '{idx: 0, rs: 1'b0, data: 8'h00, exp_grant: 4'b0001};
    tbl[2] = '{idx: 2, rs: 1'b1, data: 8'hFF, exp_grant: 4'b0100};
    tbl[3] = '{idx: 3, rs: 1'b0, data: 8'h7E, exp_grant: 4'b1000};

    repeat (3) tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_e", 32'(LCD_E), 32'd0);
    chk("rst_rs", 32'(LCD_RS), 32'd1);
    chk("rst_rw", 32'(LCD_RW), 32'd1);
    chk("rst_data", 32'(LCD_DATA), 32'd0);

    // Early request from requester 3 during power-up.
    RESET = 1'b1;
    req[3] = 1'b1;
    req_rs[3] = 1'b1;
    req_data[31:24] = 8'h55;
    push_init();
    push(1'b1, 8'h55, 4'b1000);
    repeat (70) tick();
    chk("pwrup_data", 32'(LCD_DATA), 32'd0);
    chk("pwrup_grant", 32'(grant), 32'd0);
    tick();
    chk("fset_data", 32'(LCD_DATA), 32'h3C);
    chk("fset_rs", 32'(LCD_RS), 32'd0);
    chk("fset_grant", 32'(grant), 32'd0);
    cyc = 0;
    for (int i = 0; i < 60 && !init_done; i++) begin
      tick();
      cyc++;
    end
    chk("init_cycles", 32'(cyc), 32'd26);
    chk("init_done", 32'(init_done), 32'd1);
    chk("idle_grant", 32'(grant), 32'd0);
    tick();
    chk("early_grant", 32'(grant), 32'b1000);
    wait_ack(3);
    req[3] = 1'b0;
    tick();
    chk("early_release", 32'(grant), 32'd0);

    for (int i = 0; i < 4; i++) do_write(tbl[i]);

    // Contention: all four request, each drops on its own ack.
    req_rs = 4'b1111;
    req_data = 32'h13121110;
    for (int n = 0; n < 4; n++)
      push(1'b1, 8'(8'h10 + n), 4'(4'b0001 << n));
    req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 40 && ack == 4'b0000; i++) tick();
      chk("cont_ack", 32'(ack), 32'(4'b0001 << n));
      req = req & ~ack;
      tick();
    end
    req = 4'b0000;
    tick();

    // Move pointer to 2, then burst on requester 2 with 0 waiting.
    do_write('{idx: 1, rs: 1'b1, data: 8'h20, exp_grant: 4'b0010});
    req_rs = 4'b0101;
    req_data[23:16] = 8'h30;
    req_data[7:0] = 8'hA0;
    push(1'b1, 8'h30, 4'b0100);
    push(1'b1, 8'h31, 4'b0100);
    push(1'b1, 8'h32, 4'b0100);
    push(1'b1, 8'hA0, 4'b0001);
    req = 4'b0101;
    for (int b = 0; b < 3; b++) begin
      wait_ack(2);
      chk("burst_ack", 32'(ack), 32'b0100);
      if (b < 2) req_data[23:16] = 8'(8'h31 + b);
      else req[2] = 1'b0;
      tick();
      if (b < 2) begin
        chk("burst_keep", 32'(grant), 32'b0100);
        chk("burst_data", 32'(LCD_DATA), 32'(8'h31 + b));
      end else begin
        chk("burst_release", 32'(grant), 32'd0);
      end
    end
    wait_ack(0);
    chk("burst_next_ack", 32'(ack), 32'b0001);
    req[0] = 1'b0;
    tick();
    chk("burst_next_release", 32'(grant), 32'd0);

    // Reset in the middle of a transfer.
    snap = ack_cnt[1];
    req[1] = 1'b1;
    req_rs[1] = 1'b1;
    req_data[15:8] = 8'h99;
    push(1'b1, 8'h99, 4'b0010);
    wait_grant();
    chk("abort_grant", 32'(grant), 32'b0010);
    tick();
    tick();
    chk("abort_k2_e", 32'(LCD_E), 32'd1);
    RESET = 1'b0;
    tick();
    chk("abort_e", 32'(LCD_E), 32'd0);
    chk("abort_rs", 32'(LCD_RS), 32'd1);
    chk("abort_rw", 32'(LCD_RW), 32'd1);
    chk("abort_data", 32'(LCD_DATA), 32'd0);
    chk("abort_grant0", 32'(grant), 32'd0);
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_init_done", 32'(init_done), 32'd0);
    req[1] = 1'b0;
    tick();
    RESET = 1'b1;
    push_init();
    for (int i = 0; i < 200 && !init_done; i++) tick();
    chk("reinit_done", 32'(init_done), 32'd1);
    repeat (3) tick();
    chk("abort_no_ack", 32'(ack_cnt[1]), 32'(snap));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Owns the character-LCD bus for the digital watch.
- Runs the HD44780 power-up/init command sequence once after reset.
- Then shares the single LCD write port between N display requesters (time, date, alarm, stopwatch, ...) using request/grant/ack and round-robin fairness.
- Sits between the mode modules and the LCD_E/LCD_RS/LCD_RW/LCD_DATA pins, replacing per-mode output muxing.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- PWRUP_CYC, 70, CLK_1k cycles waited after reset before the first command.
- XFER_CYC, 4, cycles per byte transfer (min 3).
- CMD_GAP, 2, idle cycles after each init command (clear display uses CMD_GAP+2).

Ports:
- CLK_1k  in  1  system clock (1 kHz).
- RESET  in  1  synchronous reset, active-low.
- req  in  N_REQ  per-requester write request; level, held while the requester has bytes.
- req_rs  in  N_REQ  per-requester RS for its current byte (0 = command, 1 = data).
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- grant  out  N_REQ  one-hot owner of the bus; all zero when the bus has no owner.
- ack  out  N_REQ  one-cycle pulse to the owner when its byte has been written.
- init_done  out  1  high once the init sequence completes; stays high until reset.
- LCD_E  out  1  enable strobe.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  read/write; always 0 during transfers.
- LCD_DATA  out  8  data bus.

Behaviour:
- Reset (RESET low at a CLK_1k edge):
  - state=PWRUP, counters=0, RR pointer=0.
  - grant=0, ack=0, init_done=0.
  - LCD_E=0, LCD_RS=1, LCD_RW=1, LCD_DATA=8'h00.
  - Reset asserted mid-transfer aborts at the next edge and gives no ack; init reruns in full.
- FSM states: PWRUP -> FSET(8'h3C) -> DISP(8'h0C) -> ENTRY(8'h06) -> CLR(8'h01) -> IDLE <-> XFER.
  - PWRUP lasts PWRUP_CYC+1 cycles.
  - Each init state is one XFER_CYC-cycle transfer with RS=0, followed by its gap.
  - init_done rises on the cycle IDLE is first entered.
- Transfer timing, cycle k = 0..XFER_CYC-1:
  - LCD_RS, LCD_RW=0 and LCD_DATA are stable for all k.
  - LCD_E=1 only for k = 1..XFER_CYC-2.
  - Byte and RS are latched at k=0 and not re-sampled.
- Idle bus: LCD_E=0, LCD_RS=1, LCD_RW=1, LCD_DATA=8'h00.
- Requests during PWRUP or init are ignored; grant stays 0 and the requests stay pending.
- Arbitration, in IDLE with init_done:
  - If any req is set, grant the first set req at or after the RR pointer (wrapping at N_REQ).
  - grant is registered, so it is asserted one cycle after the IDLE decision.
  - XFER k=0 starts in the same cycle as grant, using the owner's req_rs/req_data.
- Ack and burst:
  - ack[owner] pulses on the cycle after k=XFER_CYC-1.
  - Burst: if req[owner] is still 1 on the ack cycle, the owner keeps grant and the next XFER starts on the following cycle.
  - Otherwise grant drops to 0, the RR pointer becomes owner+1 mod N_REQ, and the FSM returns to IDLE.
- Owner drops req mid-transfer: the byte still completes and ack is issued; the bus is then released.
- Simultaneous requests: exactly one grant; RR order guarantees each requester is served within N_REQ-1 other bursts.
- Invariants: grant is one-hot or zero; ack is only ever a subset of grant.

Decomposition:
- Shared package lcd_pkg holds:
  - HD44780 command constants (FUNC_SET_8B2L=8'h3C, DISP_ON=8'h0C, ENTRY_INC=8'h06, CLEAR=8'h01).
  - FSM state encodings (4-bit).
  - Idle-bus constants.
- One sub-module, lcd_rr_arbiter: combinational round-robin picker (req, pointer -> one-hot winner, valid). The pointer register stays in the parent.

Test Plan:
- Init: release RESET with no requests -> after 71 cycles LCD_DATA shows 3C, 0C, 06, 01 in order, each with an E high pulse of 2 cycles and RS=0, RW=0; init_done rises once the sequence completes.
- Single write: after init, req[1]=1, req_rs[1]=1, data=8'h41 held 1 cycle past ack -> grant=0010, LCD_DATA=41 with RS=1 for 4 cycles, ack[1] pulses once, grant returns to 0.
- Contention: req=1111 held constant, each requester drops req on its own ack -> grant order 0001, 0010, 0100, 1000, with exactly one ack each.
- Burst: req[2] held for 3 acks with data 30, 31, 32 while req[0]=1 -> three back-to-back transfers to requester 2, then grant moves to requester 0 (RR pointer=3 wraps to 0).
- Early request: req[3]=1 asserted during PWRUP -> no grant until init_done, then granted immediately.
- Mid-transfer reset: RESET low at k=2 of a transfer -> next edge LCD_E=0, RS=1, RW=1, DATA=00, grant=0, no ack; init sequence repeats.
